renode_ahb_memory_subordinate: RTL and testbench
================================================

RENODE_AHB_MEMORY_SUBORDINATE -- requirements
Module: renode_ahb_memory_subordinate

Interface
REQ-001 SHALL provide parameter AddressWidth, default 32, haddr width in bits.
REQ-002 SHALL provide parameter DataWidth, default 32, data bus width; legal values 8/16/32/64.
REQ-003 SHALL provide parameter MemoryDepth, default 1024, number of DataWidth-bit words stored.
REQ-004 SHALL provide parameter WaitStates, default 0, wait cycles inserted in every valid data phase; range 0..15.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: hclk input 1 (rising edge) and hresetn input 1 (asynchronous, active-low).
REQ-006 SHALL provide the port hsel  input  1  subordinate select.
REQ-007 SHALL provide the port haddr  input  AddressWidth  byte address, offset from 0.
REQ-008 SHALL provide the ports htrans input 2 (Idle/Busy/NonSequential/Sequential), hwrite input 1, hsize input 3 and hburst input 3.
REQ-009 SHALL provide the ports hwstrb  input  DataWidth/8  write lane strobes, and hwdata  input  DataWidth  write data.
REQ-010 SHALL provide the port hready  input  1  bus-level ready, used for address-phase qualification.
REQ-011 SHALL provide the ports hreadyout output 1, hresp output 1 (0 Okay, 1 Error) and hrdata output DataWidth.

Function
REQ-012 SHALL accept an address phase only when hsel && hready && htrans in {NonSequential, Sequential}, registering haddr, hwrite and hsize.
- Idle/Busy/unselected: no access, zero-wait Okay.
REQ-013 SHALL implement the states IDLE, WAIT, ERR1 and ERR2.
- Accepted valid transfer: IDLE->WAIT if WaitStates>0, else complete next cycle.
- Counter reaches WaitStates: WAIT->IDLE.
- Invalid transfer: ->ERR1->ERR2->IDLE.
REQ-014 SHALL drive hreadyout=0 in WAIT and ERR1, and hreadyout=1 otherwise.
REQ-015 SHALL drive hresp=1 in ERR1 and ERR2 only, giving the standard two-cycle error response.
REQ-016 SHALL commit a write on the final data-phase cycle (hreadyout=1).
- hwdata sampled on that cycle.
- Byte enables = size/address-derived lane mask AND hwstrb.
REQ-017 SHALL present read data on hrdata in the final data-phase cycle, with unselected lanes zero.
- Total read latency = 1 + WaitStates cycles after address-phase acceptance.
REQ-018 SHALL accept a new address phase in the final data-phase cycle of the previous transfer (pipelined).
- A read immediately following a write to the same word SHALL return the newly written bytes.
REQ-019 SHALL treat a transfer as invalid when any of the following hold:
- 8<<hsize > DataWidth;
- haddr is not aligned to 1<<hsize;
- haddr >= MemoryDepth*DataWidth/8.
REQ-020 SHALL perform no memory update for an invalid write, and SHALL drive hrdata=0 for an invalid read.
REQ-021 SHALL treat hburst as informational only; each beat is decoded independently.

Reset
REQ-022 SHALL, on hresetn low, asynchronously force IDLE, hreadyout=1, hresp=0, hrdata=0 and wait counter=0.
- Any in-flight transfer, including a pending write, is discarded.
REQ-023 SHALL NOT clear memory contents on reset.

Configuration
REQ-024 SHALL, when RENODE_AHB_SUBORDINATE_ERROR_EN is defined, produce the Error responses of REQ-015 and REQ-019.
REQ-025 SHALL, when RENODE_AHB_SUBORDINATE_ERROR_EN is undefined, never assert hresp or enter ERR1/ERR2.
- Invalid reads return 0 with Okay after normal wait states.
- Invalid writes are silently dropped.

Structure
REQ-026 SHALL take the htrans, hburst and response enums and the transfer-size helpers from renode_ahb_pkg, with no local duplicates.
REQ-027 SHALL place the storage in sub-module renode_ahb_memory_array: one write port with byte enables, one read port, parameterized by DataWidth and MemoryDepth.

Verification
REQ-028 SHALL cover single-word write/read (WaitStates=0): write 0xDEADBEEF to 0x10, then read 0x10 -> 0xDEADBEEF, hresp=0, no hreadyout low.
REQ-029 SHALL cover wait states (WaitStates=3): read 0x20 -> hreadyout low for exactly 3 cycles, then data returned with Okay.
REQ-030 SHALL cover byte-lane writes: write byte 0xAA at 0x13 with hsize=0, then read word 0x10 -> 0xAA in bits 31:24, other bytes unchanged.
REQ-031 SHALL cover errors with ERROR_EN defined: read 0x1000 with MemoryDepth=1024 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); a halfword at 0x11 also errors.
REQ-032 SHALL cover pipelining: back-to-back write 0x5 to 0x40 then read 0x40 -> read returns 0x5 with no idle cycle between the transfers.
REQ-033 SHALL cover reset mid-operation: hresetn low during WAIT -> hreadyout=1, hresp=0, hrdata=0 immediately; the next read of the interrupted write address shows the old data.

Source files
------------

// File: rtl/renode_ahb_pkg.sv
// Shared AHB definitions for the Renode AHB memory subordinate: transfer enums,
// response codes, FSM states and transfer-size helpers.
package renode_ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } hburst_e;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } sub_state_e;

   function automatic logic [31:0] size_bytes(input logic [2:0] hsize);
      return 32'd1 << hsize;
   endfunction

   // Byte-lane mask of a transfer within an 8-lane word, before trimming to the bus width.
   function automatic logic [7:0] size_lane_mask(input logic [2:0] hsize, input logic [2:0] offset);
      logic [7:0] base;
      case (hsize)
         3'd0:    base = 8'h01;
         3'd1:    base = 8'h03;
         3'd2:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << offset;
   endfunction

endpackage

// File: rtl/renode_ahb_memory_subordinate_if.sv
// AHB-Lite subordinate bus bundle; master side drives requests, slave side responds.
interface renode_ahb_memory_subordinate_if #(
   parameter int AddressWidth = 32,
   parameter int DataWidth    = 32
);
   import renode_ahb_pkg::*;

   logic                    hsel;
   logic [AddressWidth-1:0] haddr;
   htrans_e                 htrans;
   logic                    hwrite;
   logic [2:0]              hsize;
   hburst_e                 hburst;
   logic [DataWidth/8-1:0]  hwstrb;
   logic [DataWidth-1:0]    hwdata;
   logic                    hready;
   logic                    hreadyout;
   logic                    hresp;
   logic [DataWidth-1:0]    hrdata;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hwstrb, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hwstrb, hwdata, hready,
      output hreadyout, hresp, hrdata
   );

endinterface

// File: rtl/renode_ahb_memory_array.sv
// Word-organised storage with one byte-enabled write port and one asynchronous read port.
// Contents are deliberately not reset.
module renode_ahb_memory_array #(
   parameter  int DataWidth   = 32,
   parameter  int MemoryDepth = 1024,
   localparam int Lanes       = DataWidth / 8,
   localparam int IdxBits     = (MemoryDepth > 1) ? $clog2(MemoryDepth) : 1
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [Lanes-1:0]     wr_be,
   input  logic [IdxBits-1:0]   wr_idx,
   input  logic [DataWidth-1:0] wr_data,
   input  logic [IdxBits-1:0]   rd_idx,
   output logic [DataWidth-1:0] rd_data
);

   logic [DataWidth-1:0] mem_q [MemoryDepth];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < Lanes; b++) begin
            if (wr_be[b]) begin
               mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/renode_ahb_memory_subordinate.sv
// AHB-Lite memory subordinate with configurable wait states.
// Define RENODE_AHB_SUBORDINATE_ERROR_EN to return two-cycle Error responses for invalid transfers.
module renode_ahb_memory_subordinate
   import renode_ahb_pkg::*;
#(
   parameter int AddressWidth = 32,
   parameter int DataWidth    = 32,
   parameter int MemoryDepth  = 1024,
   parameter int WaitStates   = 0
) (
   input logic                     hclk,
   input logic                     hresetn,
   renode_ahb_memory_subordinate_if.slave bus
);

   localparam int           Lanes     = DataWidth / 8;
   localparam int           IdxBits   = (MemoryDepth > 1) ? $clog2(MemoryDepth) : 1;
   localparam int           LaneShift = $clog2(Lanes);
   localparam logic [63:0]  ByteCap   = 64'(MemoryDepth) * 64'(Lanes);
   localparam logic [3:0]   WaitLast  = 4'(WaitStates);
`ifdef RENODE_AHB_SUBORDINATE_ERROR_EN
   localparam bit           ErrorEn   = 1'b1;
`else
   localparam bit           ErrorEn   = 1'b0;
`endif

   sub_state_e              state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    pend_q, pend_d;
   logic                    valid_q, valid_d;
   logic                    write_q, write_d;
   logic [2:0]              size_q, size_d;
   logic [AddressWidth-1:0] addr_q, addr_d;

   logic                    accept;
   logic                    req_valid;
   logic                    commit;
   logic                    wr_en;
   logic [7:0]              lane_mask8;
   logic [Lanes-1:0]        lane_mask;
   logic [DataWidth-1:0]    byte_mask;
   logic [DataWidth-1:0]    rd_word;
   logic [IdxBits-1:0]      word_idx;

   always_comb begin
      accept    = bus.hsel && bus.hready &&
                  (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);
      req_valid = ((32'd8 << bus.hsize) <= 32'(DataWidth)) &&
                  ((64'(bus.haddr) & 64'(size_bytes(bus.hsize) - 32'd1)) == 64'd0) &&
                  (64'(bus.haddr) < ByteCap);
   end

   // A new address phase is only taken while the previous data phase is completing (or idle).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      valid_d = valid_q;
      write_d = write_q;
      size_d  = size_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE, ST_ERR2: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            pend_d  = 1'b0;
            if (accept) begin
               pend_d  = 1'b1;
               valid_d = req_valid;
               write_d = bus.hwrite;
               size_d  = bus.hsize;
               addr_d  = bus.haddr;
               if (ErrorEn && !req_valid) begin
                  state_d = ST_ERR1;
               end else if (WaitStates > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'd1;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == WaitLast) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         pend_q  <= 1'b0;
         valid_q <= 1'b0;
         write_q <= 1'b0;
         size_q  <= 3'd0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         write_q <= write_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
      end
   end

   // The final data-phase cycle is IDLE with a pending valid transfer.
   always_comb begin
      commit     = (state_q == ST_IDLE) && pend_q && valid_q;
      wr_en      = commit && write_q;
      lane_mask8 = size_lane_mask(size_q, 3'(addr_q) & 3'(Lanes - 1));
      lane_mask  = lane_mask8[Lanes-1:0];
      word_idx   = IdxBits'(addr_q >> LaneShift);
      byte_mask  = '0;
      for (int b = 0; b < Lanes; b++) begin
         byte_mask[b*8 +: 8] = {8{lane_mask[b]}};
      end
      bus.hrdata    = (commit && !write_q) ? (rd_word & byte_mask) : '0;
      bus.hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
      bus.hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   end

   renode_ahb_memory_array #(
      .DataWidth   (DataWidth),
      .MemoryDepth (MemoryDepth)
   ) u_array (
      .clk     (hclk),
      .wr_en   (wr_en),
      .wr_be   (lane_mask & bus.hwstrb),
      .wr_idx  (word_idx),
      .wr_data (bus.hwdata),
      .rd_idx  (word_idx),
      .rd_data (rd_word)
   );

endmodule

// File: tb/tb_renode_ahb_memory_subordinate.sv
// Directed bench for the AHB memory subordinate: one zero-wait and one three-wait instance
// share the request signals and are selected individually.
module tb_renode_ahb_memory_subordinate;
   import renode_ahb_pkg::*;

   logic        hclk = 1'b0;
   logic        hresetn = 1'b1;
   logic        sel0, sel3;
   logic [31:0] haddr;
   htrans_e     htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   hburst_e     hburst;
   logic [3:0]  hwstrb;
   logic [31:0] hwdata;
   int          errors = 0;
   int          checks = 0;

   renode_ahb_memory_subordinate_if #(.AddressWidth(32), .DataWidth(32)) bus0 ();
   renode_ahb_memory_subordinate_if #(.AddressWidth(32), .DataWidth(32)) bus3 ();

   assign bus0.hsel   = sel0;
   assign bus0.haddr  = haddr;
   assign bus0.htrans = htrans;
   assign bus0.hwrite = hwrite;
   assign bus0.hsize  = hsize;
   assign bus0.hburst = hburst;
   assign bus0.hwstrb = hwstrb;
   assign bus0.hwdata = hwdata;
   assign bus0.hready = bus0.hreadyout;
   assign bus3.hsel   = sel3;
   assign bus3.haddr  = haddr;
   assign bus3.htrans = htrans;
   assign bus3.hwrite = hwrite;
   assign bus3.hsize  = hsize;
   assign bus3.hburst = hburst;
   assign bus3.hwstrb = hwstrb;
   assign bus3.hwdata = hwdata;
   assign bus3.hready = bus3.hreadyout;

   renode_ahb_memory_subordinate #(.AddressWidth(32), .DataWidth(32), .MemoryDepth(1024), .WaitStates(0)) u_dut0 (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus0)
   );

   renode_ahb_memory_subordinate #(.AddressWidth(32), .DataWidth(32), .MemoryDepth(1024), .WaitStates(3)) u_dut3 (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus3)
   );

   always #5 hclk = ~hclk;

   function automatic logic rdy_of(input int which);
      return (which == 0) ? bus0.hreadyout : bus3.hreadyout;
   endfunction

   function automatic logic resp_of(input int which);
      return (which == 0) ? bus0.hresp : bus3.hresp;
   endfunction

   function automatic logic [31:0] rdata_of(input int which);
      return (which == 0) ? bus0.hrdata : bus3.hrdata;
   endfunction

   // One non-pipelined transfer: address phase, then wait for the completing data-phase cycle.
   task automatic xfer(input int which, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata, output int low, output logic resp_low, output logic resp_fin);
      @(negedge hclk);
      sel0   = (which == 0);
      sel3   = (which != 0);
      haddr  = addr;
      htrans = HTRANS_NONSEQ;
      hwrite = wr;
      hsize  = size;
      hburst = HBURST_SINGLE;
      @(posedge hclk);
      #1;
      sel0     = 1'b0;
      sel3     = 1'b0;
      htrans   = HTRANS_IDLE;
      hwdata   = wdata;
      hwstrb   = strb;
      low      = 0;
      resp_low = 1'b0;
      resp_fin = 1'b0;
      rdata    = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge hclk);
         if (rdy_of(which)) begin
            rdata    = rdata_of(which);
            resp_fin = resp_of(which);
            break;
         end
         low++;
         resp_low = resp_low | resp_of(which);
      end
      if (low >= 20) begin
         checks++;
         errors++;
         $display("[TB] FAIL xfer_timeout: addr=%h hreadyout stayed low for %0d cycles, required completion", addr, low);
      end
      @(posedge hclk);
      #1;
   endtask

   task automatic test_reset();
      #2 hresetn = 1'b0;
      #3;
      checks++; if (bus0.hreadyout !== 1'b1) begin errors++; $display("[TB] FAIL reset_hreadyout0: got %b want 1", bus0.hreadyout); end
      checks++; if (bus0.hresp !== 1'b0) begin errors++; $display("[TB] FAIL reset_hresp0: got %b want 0", bus0.hresp); end
      checks++; if (bus0.hrdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_hrdata0: got %h want 0", bus0.hrdata); end
      checks++; if (bus3.hreadyout !== 1'b1) begin errors++; $display("[TB] FAIL reset_hreadyout3: got %b want 1", bus3.hreadyout); end
      checks++; if (bus3.hresp !== 1'b0) begin errors++; $display("[TB] FAIL reset_hresp3: got %b want 0", bus3.hresp); end
      checks++; if (bus3.hrdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_hrdata3: got %h want 0", bus3.hrdata); end
      @(negedge hclk);
      hresetn = 1'b1;
   endtask

   task automatic test_single_word();
      logic [31:0] rd; int low; logic rl, rf;
      xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 4'hF, rd, low, rl, rf);
      checks++; if (low !== 0) begin errors++; $display("[TB] FAIL single_wr_waits: got %0d want 0", low); end
      checks++; if (rf !== 1'b0) begin errors++; $display("[TB] FAIL single_wr_resp: got %b want 0", rf); end
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 4'h0, rd, low, rl, rf);
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_rd_data: got %h want deadbeef", rd); end
      checks++; if (low !== 0) begin errors++; $display("[TB] FAIL single_rd_waits: got %0d want 0", low); end
      checks++; if (rf !== 1'b0) begin errors++; $display("[TB] FAIL single_rd_resp: got %b want 0", rf); end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd; int low; logic rl, rf;
      xfer(3, 1'b1, 32'h20, 3'd2, 32'h12345678, 4'hF, rd, low, rl, rf);
      checks++; if (low !== 3) begin errors++; $display("[TB] FAIL wait_wr_low: got %0d want 3", low); end
      xfer(3, 1'b0, 32'h20, 3'd2, 32'h0, 4'h0, rd, low, rl, rf);
      checks++; if (low !== 3) begin errors++; $display("[TB] FAIL wait_rd_low: got %0d want 3", low); end
      checks++; if (rd !== 32'h12345678) begin errors++; $display("[TB] FAIL wait_rd_data: got %h want 12345678", rd); end
      checks++; if ((rl | rf) !== 1'b0) begin errors++; $display("[TB] FAIL wait_rd_resp: got %b want 0", rl | rf); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd; int low; logic rl, rf;
      xfer(0, 1'b1, 32'h13, 3'd0, 32'hAA000000, 4'hF, rd, low, rl, rf);
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 4'h0, rd, low, rl, rf);
      checks++; if (rd !== 32'hAAADBEEF) begin errors++; $display("[TB] FAIL byte_write: got %h want aaadbeef", rd); end
      xfer(0, 1'b1, 32'h10, 3'd1, 32'h00001234, 4'b0001, rd, low, rl, rf);
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 4'h0, rd, low, rl, rf);
      checks++; if (rd !== 32'hAAADBE34) begin errors++; $display("[TB] FAIL strobe_gating: got %h want aaadbe34", rd); end
      xfer(0, 1'b0, 32'h11, 3'd0, 32'h0, 4'h0, rd, low, rl, rf);
      checks++; if (rd !== 32'h0000BE00) begin errors++; $display("[TB] FAIL byte_read_lanes: got %h want 0000be00", rd); end
   endtask

   task automatic test_idle_busy();
      logic [31:0] rd; int low; logic rl, rf;
      @(negedge hclk);
      sel0 = 1'b1; haddr = 32'h10; htrans = HTRANS_BUSY; hwrite = 1'b1; hsize = 3'd2;
      @(posedge hclk);
      #1;
      sel0 = 1'b0; htrans = HTRANS_NONSEQ; hwdata = 32'hFFFFFFFF; hwstrb = 4'hF;
      @(negedge hclk);
      checks++; if (bus0.hreadyout !== 1'b1) begin errors++; $display("[TB] FAIL busy_ready: got %b want 1", bus0.hreadyout); end
      checks++; if (bus0.hresp !== 1'b0) begin errors++; $display("[TB] FAIL busy_resp: got %b want 0", bus0.hresp); end
      @(posedge hclk);
      #1;
      htrans = HTRANS_IDLE;
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 4'h0, rd, low, rl, rf);
      checks++; if (rd !== 32'hAAADBE34) begin errors++; $display("[TB] FAIL busy_no_write: got %h want aaadbe34", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; int low; logic rl, rf;
      logic [31:0] bad_addr [3];
      logic [2:0]  bad_size [3];
      bad_addr[0] = 32'h1000; bad_size[0] = 3'd2;
      bad_addr[1] = 32'h11;   bad_size[1] = 3'd1;
      bad_addr[2] = 32'h18;   bad_size[2] = 3'd3;
      for (int k = 0; k < 3; k++) begin
         xfer(0, 1'b0, bad_addr[k], bad_size[k], 32'h0, 4'h0, rd, low, rl, rf);
         checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL err_rdata[%0d]: got %h want 0", k, rd); end
`ifdef RENODE_AHB_SUBORDINATE_ERROR_EN
         checks++; if (low !== 1) begin errors++; $display("[TB] FAIL err_err1_len[%0d]: got %0d want 1", k, low); end
         checks++; if (rl !== 1'b1) begin errors++; $display("[TB] FAIL err_err1_resp[%0d]: got %b want 1", k, rl); end
         checks++; if (rf !== 1'b1) begin errors++; $display("[TB] FAIL err_err2_resp[%0d]: got %b want 1", k, rf); end
`else
         checks++; if (low !== 0) begin errors++; $display("[TB] FAIL noerr_waits[%0d]: got %0d want 0", k, low); end
         checks++; if (rf !== 1'b0) begin errors++; $display("[TB] FAIL noerr_resp[%0d]: got %b want 0", k, rf); end
`endif
      end
      xfer(0, 1'b1, 32'h12, 3'd2, 32'hFFFFFFFF, 4'hF, rd, low, rl, rf);
      xfer(0, 1'b1, 32'h1000, 3'd2, 32'hFFFFFFFF, 4'hF, rd, low, rl, rf);
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 4'h0, rd, low, rl, rf);
      checks++; if (rd !== 32'hAAADBE34) begin errors++; $display("[TB] FAIL err_write_dropped: got %h want aaadbe34", rd); end
      xfer(3, 1'b0, 32'h1000, 3'd2, 32'h0, 4'h0, rd, low, rl, rf);
`ifdef RENODE_AHB_SUBORDINATE_ERROR_EN
      checks++; if (low !== 1) begin errors++; $display("[TB] FAIL err_wait_inst_len: got %0d want 1", low); end
`else
      checks++; if (low !== 3) begin errors++; $display("[TB] FAIL noerr_wait_inst_len: got %0d want 3", low); end
`endif
   endtask

   task automatic test_back_to_back();
      @(negedge hclk);
      sel0 = 1'b1; haddr = 32'h40; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = 3'd2; hburst = HBURST_INCR;
      @(posedge hclk);
      #1;
      hwdata = 32'h5; hwstrb = 4'hF; hwrite = 1'b0; htrans = HTRANS_SEQ;
      @(negedge hclk);
      checks++; if (bus0.hreadyout !== 1'b1) begin errors++; $display("[TB] FAIL b2b_wr_ready: got %b want 1", bus0.hreadyout); end
      @(posedge hclk);
      #1;
      sel0 = 1'b0; htrans = HTRANS_IDLE;
      @(negedge hclk);
      checks++; if (bus0.hreadyout !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rd_ready: got %b want 1", bus0.hreadyout); end
      checks++; if (bus0.hrdata !== 32'h5) begin errors++; $display("[TB] FAIL b2b_rd_data: got %h want 00000005", bus0.hrdata); end
      checks++; if (bus0.hresp !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rd_resp: got %b want 0", bus0.hresp); end
      @(posedge hclk);
      #1;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; int low; logic rl, rf;
      xfer(3, 1'b1, 32'h50, 3'd2, 32'h11111111, 4'hF, rd, low, rl, rf);
      @(negedge hclk);
      sel3 = 1'b1; haddr = 32'h50; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = 3'd2;
      @(posedge hclk);
      #1;
      sel3 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h22222222; hwstrb = 4'hF;
      @(negedge hclk);
      checks++; if (bus3.hreadyout !== 1'b0) begin errors++; $display("[TB] FAIL mid_in_wait: got %b want 0", bus3.hreadyout); end
      #2 hresetn = 1'b0;
      #1;
      checks++; if (bus3.hreadyout !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_ready: got %b want 1", bus3.hreadyout); end
      checks++; if (bus3.hresp !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_resp: got %b want 0", bus3.hresp); end
      checks++; if (bus3.hrdata !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_rdata: got %h want 0", bus3.hrdata); end
      @(negedge hclk);
      hresetn = 1'b1;
      xfer(3, 1'b0, 32'h50, 3'd2, 32'h0, 4'h0, rd, low, rl, rf);
      checks++; if (rd !== 32'h11111111) begin errors++; $display("[TB] FAIL mid_old_data: got %h want 11111111", rd); end
      xfer(0, 1'b0, 32'h40, 3'd2, 32'h0, 4'h0, rd, low, rl, rf);
      checks++; if (rd !== 32'h5) begin errors++; $display("[TB] FAIL mem_retained: got %h want 00000005", rd); end
   endtask

   initial begin
      sel0 = 1'b0; sel3 = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
      hsize = 3'd0; hburst = HBURST_SINGLE; hwstrb = '0; hwdata = '0;
      test_reset();
      test_single_word();
      test_wait_states();
      test_byte_lanes();
      test_idle_busy();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
